mybullet_app: RTL and testbench

Bullet engine for the player's tank: the responder side of the tank's shoot request. It accepts the tank's `bul_sht` request together with the tank position and direction. It then launches a single bullet, steps it across the playfield grid at a fixed rate and reports in-flight status back to the tank on `mybul_state_feedback`. The bullet position goes to the display path and to the enemy hit logic.

---
 rtl/mybullet_app.sv | 136 +++++++++++++
 tb/tb_mybullet_app.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mybullet_app.sv
// rtl/mybullet_app.sv - player tank bullet engine: launch, fixed-rate grid stepping, border exit
// Enemy hit detection is built only when MYBULLET_HIT_DETECT_EN is defined.
module mybullet_app #(
  parameter int X_MAX    = 16,
  parameter int Y_MAX    = 20,
  parameter int STEP_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bul_en,
  input  logic       bul_sht,
  input  logic [4:0] tank_x,
  input  logic [4:0] tank_y,
  input  logic [1:0] tank_dir,
  input  logic [4:0] enemy1_x,
  input  logic [4:0] enemy2_x,
  input  logic [4:0] enemy3_x,
  input  logic [4:0] enemy4_x,
  input  logic [4:0] enemy1_y,
  input  logic [4:0] enemy2_y,
  input  logic [4:0] enemy3_y,
  input  logic [4:0] enemy4_y,
  input  logic [3:0] enemy_alive,
  output logic [4:0] bul_x,
  output logic [4:0] bul_y,
  output logic [1:0] bul_dir,
  output logic       mybul_state_feedback,
  output logic [3:0] hit_enemy
);

  localparam int              CW       = $clog2(STEP_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [4:0]      X_LAST   = 5'(X_MAX - 1);
  localparam logic [4:0]      Y_LAST   = 5'(Y_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLY  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] step_cnt;
  logic [4:0]    nx;
  logic [4:0]    ny;
  logic          next_ok;
  logic [3:0]    hit_now;

  // 5-bit wrap (0 - 1 = 31) lands outside the field, so one range test covers it
  always_comb begin
    nx = bul_x;
    ny = bul_y;
    case (bul_dir)
      2'b00:   ny = bul_y + 5'd1;
      2'b01:   ny = bul_y - 5'd1;
      2'b10:   nx = bul_x + 5'd1;
      default: nx = bul_x - 5'd1;
    endcase
    next_ok = (nx != 5'd0) && (nx <= X_LAST) && (ny != 5'd0) && (ny <= Y_LAST);
  end

`ifdef MYBULLET_HIT_DETECT_EN
  always_comb begin
    hit_now    = 4'b0000;
    hit_now[0] = (bul_x == enemy1_x) && (bul_y == enemy1_y);
    hit_now[1] = (bul_x == enemy2_x) && (bul_y == enemy2_y);
    hit_now[2] = (bul_x == enemy3_x) && (bul_y == enemy3_y);
    hit_now[3] = (bul_x == enemy4_x) && (bul_y == enemy4_y);
    hit_now    = hit_now & enemy_alive;
  end
`else
  logic unused_enemy;
  assign hit_now      = 4'b0000;
  assign unused_enemy = ^{enemy1_x, enemy2_x, enemy3_x, enemy4_x,
                          enemy1_y, enemy2_y, enemy3_y, enemy4_y, enemy_alive};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      step_cnt             <= '0;
      bul_x                <= 5'd0;
      bul_y                <= 5'd0;
      bul_dir              <= 2'd0;
      mybul_state_feedback <= 1'b0;
      hit_enemy            <= 4'b0000;
    end else begin
      hit_enemy <= 4'b0000;
      case (state)
        S_IDLE: begin
          if (bul_sht && bul_en) begin
            state                <= S_FLY;
            bul_x                <= tank_x;
            bul_y                <= tank_y;
            bul_dir              <= tank_dir;
            step_cnt             <= '0;
            mybul_state_feedback <= 1'b1;
          end
        end
        S_FLY: begin
          // abort beats hit, hit beats step/border
          if (!bul_en) begin
            state    <= S_DONE;
            step_cnt <= '0;
          end else if (hit_now != 4'b0000) begin
            hit_enemy <= hit_now;
            state     <= S_DONE;
            step_cnt  <= '0;
          end else if (step_cnt == CNT_LAST) begin
            step_cnt <= '0;
            if (next_ok) begin
              bul_x <= nx;
              bul_y <= ny;
            end else begin
              state <= S_DONE;
            end
          end else begin
            step_cnt <= step_cnt + CNT_ONE;
          end
        end
        S_DONE: begin
          bul_x                <= 5'd0;
          bul_y                <= 5'd0;
          mybul_state_feedback <= 1'b0;
          step_cnt             <= '0;
          state                <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mybullet_app.sv
// tb/tb_mybullet_app.sv - bench for mybullet_app: flight model compared every cycle plus literal checkpoints
// Honours MYBULLET_HIT_DETECT_EN the same way as the design.
module tb_mybullet_app;

  localparam int STEP_DIV = 4;
  localparam int X_MAX    = 16;
  localparam int Y_MAX    = 20;
`ifdef MYBULLET_HIT_DETECT_EN
  localparam bit HIT_ON = 1'b1;
`else
  localparam bit HIT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bul_en = 1'b0;
  logic       bul_sht = 1'b0;
  logic [4:0] tank_x = 5'd0, tank_y = 5'd0;
  logic [1:0] tank_dir = 2'd0;
  logic [4:0] enemy1_x = 5'd0, enemy2_x = 5'd0, enemy3_x = 5'd0, enemy4_x = 5'd0;
  logic [4:0] enemy1_y = 5'd0, enemy2_y = 5'd0, enemy3_y = 5'd0, enemy4_y = 5'd0;
  logic [3:0] enemy_alive = 4'b0000;
  logic [4:0] bul_x, bul_y;
  logic [1:0] bul_dir;
  logic       mybul_state_feedback;
  logic [3:0] hit_enemy;

  always #5 clk = ~clk;

  mybullet_app #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .STEP_DIV(STEP_DIV)) dut (
    .clk(clk), .rst(rst), .bul_en(bul_en), .bul_sht(bul_sht),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
    .enemy1_x(enemy1_x), .enemy2_x(enemy2_x), .enemy3_x(enemy3_x), .enemy4_x(enemy4_x),
    .enemy1_y(enemy1_y), .enemy2_y(enemy2_y), .enemy3_y(enemy3_y), .enemy4_y(enemy4_y),
    .enemy_alive(enemy_alive),
    .bul_x(bul_x), .bul_y(bul_y), .bul_dir(bul_dir),
    .mybul_state_feedback(mybul_state_feedback), .hit_enemy(hit_enemy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Flight model: position = launch point + steps * unit vector; a bullet is idle, flying or ending
  localparam int M_IDLE = 0, M_FLY = 1, M_END = 2;
  int         m_phase = M_IDLE;
  int         m_lx = 0, m_ly = 0, m_steps = 0, m_age = 0;
  logic [1:0] m_dir = 2'd0;
  logic [3:0] m_hit = 4'b0000;

  function automatic int dx_of(input logic [1:0] d);
    return (d == 2'b10) ? 1 : (d == 2'b11) ? -1 : 0;
  endfunction

  function automatic int dy_of(input logic [1:0] d);
    return (d == 2'b00) ? 1 : (d == 2'b01) ? -1 : 0;
  endfunction

  function automatic logic [3:0] targets_at(input int x, input int y);
    logic [3:0] h = 4'b0000;
    int ex[4];
    int ey[4];
    ex = '{int'(enemy1_x), int'(enemy2_x), int'(enemy3_x), int'(enemy4_x)};
    ey = '{int'(enemy1_y), int'(enemy2_y), int'(enemy3_y), int'(enemy4_y)};
    for (int n = 0; n < 4; n++)
      if (enemy_alive[n] && ex[n] == x && ey[n] == y) h[n] = 1'b1;
    return HIT_ON ? h : 4'b0000;
  endfunction

  always @(posedge clk or posedge rst) begin : model_p
    int cx, cy, tx, ty;
    logic [3:0] h;
    m_hit = 4'b0000;
    if (rst) begin
      m_phase = M_IDLE; m_dir = 2'd0; m_steps = 0; m_age = 0;
    end else if (m_phase == M_IDLE) begin
      if (bul_sht && bul_en) begin
        m_phase = M_FLY; m_lx = tank_x; m_ly = tank_y; m_dir = tank_dir;
        m_steps = 0; m_age = 0;
      end
    end else if (m_phase == M_END) begin
      m_phase = M_IDLE;
    end else begin
      m_age++;
      cx = m_lx + m_steps * dx_of(m_dir);
      cy = m_ly + m_steps * dy_of(m_dir);
      h  = targets_at(cx, cy);
      if (!bul_en) m_phase = M_END;
      else if (h != 4'b0000) begin
        m_hit = h; m_phase = M_END;
      end else if (m_age % STEP_DIV == 0) begin
        tx = cx + dx_of(m_dir);
        ty = cy + dy_of(m_dir);
        if (tx >= 1 && tx <= X_MAX - 1 && ty >= 1 && ty <= Y_MAX - 1) m_steps++;
        else m_phase = M_END;
      end
    end
  end

  always @(negedge clk) begin : cmp_p
    int ex_x, ex_y;
    ex_x = (m_phase == M_IDLE) ? 0 : m_lx + m_steps * dx_of(m_dir);
    ex_y = (m_phase == M_IDLE) ? 0 : m_ly + m_steps * dy_of(m_dir);
    chk("model bul_x", bul_x, ex_x);
    chk("model bul_y", bul_y, ex_y);
    chk("model bul_dir", bul_dir, m_dir);
    chk("model feedback", mybul_state_feedback, (m_phase != M_IDLE));
    chk("model hit_enemy", hit_enemy, m_hit);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (mybul_state_feedback !== 1'b0 && k < budget) begin
      cyc(1);
      k++;
    end
    chk("wait_idle feedback", mybul_state_feedback, 0);
  endtask

  task automatic fire(input int x, input int y, input logic [1:0] d);
    tank_x = 5'(x); tank_y = 5'(y); tank_dir = d; bul_sht = 1'b1;
    cyc(1);
  endtask

  initial begin
    bul_en = 1'b1;
    cyc(2);
    chk("reset feedback", mybul_state_feedback, 0);
    chk("reset bul_x", bul_x, 0);
    chk("reset hit", hit_enemy, 0);
    rst = 1'b0;

    // reset in mid-flight clears outputs without waiting for a clock
    fire(5, 5, 2'b00);
    bul_sht = 1'b0;
    cyc(5);
    chk("pre-reset bul_y", bul_y, 6);
    rst = 1'b1;
    #1;
    chk("async reset feedback", mybul_state_feedback, 0);
    chk("async reset bul_y", bul_y, 0);
    cyc(1);
    rst = 1'b0;

    // launch and step with shoot held; then abort and relaunch from the held request
    fire(5, 5, 2'b00);
    chk("launch feedback", mybul_state_feedback, 1);
    chk("launch bul_x", bul_x, 5);
    chk("launch bul_y", bul_y, 5);
    cyc(4);
    chk("step1 bul_y", bul_y, 6);
    cyc(4);
    chk("step2 bul_y", bul_y, 7);
    bul_en = 1'b0;
    cyc(2);
    chk("abort feedback", mybul_state_feedback, 0);
    chk("abort hit", hit_enemy, 0);
    cyc(1);
    chk("disabled no launch", mybul_state_feedback, 0);
    bul_en = 1'b1;
    cyc(1);
    chk("held relaunch feedback", mybul_state_feedback, 1);
    chk("held relaunch bul_y", bul_y, 5);
    bul_sht = 1'b0; bul_en = 1'b0;
    cyc(2);
    bul_en = 1'b1;

    // left border: (2,1) -> (1,1), next would be x=0
    fire(2, 1, 2'b11);
    chk("border dir", bul_dir, 3);
    cyc(4);
    chk("border step bul_x", bul_x, 1);
    chk("border step bul_y", bul_y, 1);
    cyc(5);
    chk("border exit feedback", mybul_state_feedback, 0);
    chk("border exit bul_x", bul_x, 0);
    cyc(1);
    chk("border relaunch bul_x", bul_x, 2);
    bul_sht = 1'b0;
    wait_idle(40);

    // hit enemy2 at (5,4); enemy3 on the same cell is dead
    enemy1_x = 5'd9; enemy1_y = 5'd9;
    enemy2_x = 5'd5; enemy2_y = 5'd4;
    enemy3_x = 5'd5; enemy3_y = 5'd4;
    enemy_alive = 4'b0011;
    fire(3, 4, 2'b10);
    bul_sht = 1'b0;
    cyc(8);
    chk("hit approach bul_x", bul_x, 5);
    chk("hit approach hit", hit_enemy, 0);
    cyc(1);
    chk("hit pulse", hit_enemy, HIT_ON ? 4'b0010 : 4'b0000);
    cyc(1);
    chk("hit pulse end", hit_enemy, 0);
    chk("hit feedback", mybul_state_feedback, HIT_ON ? 0 : 1);
    wait_idle(80);

    // no live target: fly to x=15, exit when x would become 16
    enemy_alive = 4'b0000;
    fire(3, 4, 2'b10);
    bul_sht = 1'b0;
    cyc(48);
    chk("far border bul_x", bul_x, 15);
    chk("far border feedback", mybul_state_feedback, 1);
    cyc(5);
    chk("far exit feedback", mybul_state_feedback, 0);
    chk("far exit bul_x", bul_x, 0);

    // two live enemies on the launch cell
    enemy1_x = 5'd7; enemy1_y = 5'd7;
    enemy4_x = 5'd7; enemy4_y = 5'd7;
    enemy3_x = 5'd7; enemy3_y = 5'd8;
    enemy_alive = 4'b1111;
    fire(7, 7, 2'b01);
    bul_sht = 1'b0;
    cyc(1);
    chk("multi hit", hit_enemy, HIT_ON ? 4'b1001 : 4'b0000);
    wait_idle(60);

    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
